// File: rtl/chip8_memory.sv
// CHIP-8 4 KiB byte memory. After reset it writes the built-in hex fontset,
// then accepts a program image from a valid/ready byte stream, then serves
// combinational reads to the CPU. The CPU is held in reset until the image
// is complete.
module chip8_memory #(
    parameter logic [11:0] PROG_BASE = 12'h200,
    parameter logic [11:0] FONT_BASE = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic [11:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [11:0] load_count,
    output logic        load_done,
    output logic        load_error,
    output logic        cpu_hold
);

    typedef enum logic [1:0] {
        FONT_INIT = 2'd0,
        LOAD      = 2'd1,
        RUN       = 2'd2,
        ERR       = 2'd3
    } state_t;

    // Standard CHIP-8 fontset, digit 0 first; byte k lives at bits (79-k)*8 +: 8.
    localparam logic [639:0] FONT_ROM = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    localparam logic [6:0]  FONT_LAST = 7'd79;
    localparam logic [11:0] COUNT_MAX = 12'hE00;
    localparam logic [11:0] ADDR_TOP  = 12'hFFF;

    state_t      state_q, state_d;
    logic [6:0]  font_idx_q, font_idx_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] count_q, count_d;

    logic [7:0]  mem [0:4095];

    logic        transfer;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [9:0]  font_bit;
    logic [7:0]  font_byte;

    // Pick the fontset byte that the current init step writes.
    always_comb begin
        font_bit  = {FONT_LAST - font_idx_q, 3'b000};
        font_byte = FONT_ROM[font_bit +: 8];
    end

    // Next-state logic and the single array write port shared by font init and loader.
    always_comb begin
        state_d    = state_q;
        font_idx_d = font_idx_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        wr_en      = 1'b0;
        wr_addr    = ptr_q;
        wr_data    = load_data;
        transfer   = 1'b0;

        case (state_q)
            FONT_INIT: begin
                wr_en   = 1'b1;
                wr_addr = FONT_BASE + {5'b00000, font_idx_q};
                wr_data = font_byte;
                if (font_idx_q == FONT_LAST) begin
                    font_idx_d = 7'd0;
                    state_d    = LOAD;
                end else begin
                    font_idx_d = font_idx_q + 7'd1;
                end
            end
            LOAD: begin
                transfer = load_valid;
                if (transfer) begin
                    wr_en   = 1'b1;
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 12'd1;
                    // The pointer parks at the top address instead of wrapping.
                    if (ptr_q != ADDR_TOP) begin
                        ptr_d = ptr_q + 12'd1;
                    end
                    if (load_last) begin
                        state_d = RUN;
                    end else if (ptr_q == ADDR_TOP) begin
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = FONT_INIT;
            end
        endcase
    end

    // Control registers; reset restarts font init and rewinds the loader.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FONT_INIT;
            font_idx_q <= 7'd0;
            ptr_q      <= PROG_BASE;
            count_q    <= 12'd0;
        end else begin
            state_q    <= state_d;
            font_idx_q <= font_idx_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
        end
    end

    // Array write; reset blocks the write so a coincident loader byte is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero-latency CPU read, gated to zero until the program is running.
    always_comb begin
        mem_data = 8'h00;
        if (mem_read && (state_q == RUN)) begin
            mem_data = mem[mem_addr];
        end
    end

    assign load_ready = (state_q == LOAD);
    assign load_done  = (state_q == RUN);
    assign load_error = (state_q == ERR);
    assign cpu_hold   = (state_q != RUN);
    assign load_count = count_q;

endmodule

// File: tb/tb_chip8_memory.sv
// Scoreboarded bench for chip8_memory: read expectations are queued by the
// stimulus and retired by an independent monitor; status outputs are checked
// directly after each phase.
module tb_chip8_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic [11:0] load_count;
    logic        load_done;
    logic        load_error;
    logic        cpu_hold;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } readExp_t;

    readExp_t    expQ[$];
    logic [7:0]  txBytes[$];

    chip8_memory dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .load_done  (load_done),
        .load_error (load_error),
        .cpu_hold   (cpu_hold)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Monitor: every cycle the CPU strobes a read, retire the oldest expectation.
    always @(negedge clk) begin : readMonitor
        readExp_t e;
        if (mem_read === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL read_unexpected: got read at 0x%0h expected no read", mem_addr);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("read_addr_%03h", e.addr), mem_addr, e.addr);
                checkOutput($sformatf("read_data_%03h", e.addr), {4'h0, mem_data}, {4'h0, e.data});
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic readCheck(input logic [11:0] addr, input logic [7:0] data);
        readExp_t e;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
        mem_addr = addr;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkBit({tag, "_ready"}, load_ready, 1'b0);
        checkBit({tag, "_done"},  load_done,  1'b0);
        checkBit({tag, "_error"}, load_error, 1'b0);
        checkBit({tag, "_hold"},  cpu_hold,   1'b1);
        checkOutput({tag, "_count"}, load_count, 12'h000);
    endtask

    task automatic applyStimulus_reset(input string tag);
        reset      = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        mem_read   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs(tag);
        reset = 1'b0;
    endtask

    // Release happened just after an edge: cycles 1..80 are font init, 81 is LOAD.
    task automatic waitFont(input string tag);
        int early;
        early = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (load_ready !== 1'b0) early++;
            @(posedge clk);
        end
        checkOutput({tag, "_ready_low_cycles_1_80"}, 12'(early), 12'd0);
        @(negedge clk);
        checkBit({tag, "_ready_cycle_81"}, load_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Streams txBytes with valid held high; optionally marks the final byte last.
    task automatic streamTx(input bit markLast);
        int w;
        for (int i = 0; i < txBytes.size(); i++) begin
            load_valid = 1'b1;
            load_data  = txBytes[i];
            load_last  = markLast && (i == txBytes.size() - 1);
            w = 0;
            @(negedge clk);
            while (load_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (load_ready !== 1'b1) begin
                checkBit("ready_timeout", load_ready, 1'b1);
            end
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_addr   = 12'h000;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        @(posedge clk);
        #1;

        // Basic load of a four-byte program, then font and program reads in RUN.
        applyStimulus_reset("rst1");
        waitFont("font1");
        readCheck(12'h000, 8'h00);
        txBytes = '{8'h60, 8'h0A, 8'h12, 8'h02};
        streamTx(1'b1);
        checkBit("load4_done", load_done, 1'b1);
        checkBit("load4_hold", cpu_hold, 1'b0);
        checkBit("load4_ready", load_ready, 1'b0);
        checkOutput("load4_count", load_count, 12'd4);
        readCheck(12'h201, 8'h0A);
        readCheck(12'h200, 8'h60);
        readCheck(12'h202, 8'h12);
        readCheck(12'h203, 8'h02);
        readCheck(12'h000, 8'hF0);
        readCheck(12'h004, 8'hF0);
        readCheck(12'h005, 8'h20);
        readCheck(12'h00A, 8'hF0);
        readCheck(12'h00B, 8'h10);
        readCheck(12'h04B, 8'hF0);
        readCheck(12'h04C, 8'h80);
        readCheck(12'h04F, 8'h80);
        mem_addr = 12'h200;
        #1;
        checkOutput("noread_data", {4'h0, mem_data}, 12'h000);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkOutput("run_ignore_count", load_count, 12'd4);
        checkBit("run_ignore_done", load_done, 1'b1);
        readCheck(12'h203, 8'h02);

        // Alternating valid with a mid-stream stall.
        applyStimulus_reset("rst2");
        waitFont("font2");
        txBytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = txBytes[i];
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_count", load_count, 12'd3);
        checkBit("stall_ready", load_ready, 1'b1);
        txBytes = '{8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = txBytes[i];
            load_last  = (i == 2);
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            load_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("alt_count", load_count, 12'd6);
        checkBit("alt_done", load_done, 1'b1);
        readCheck(12'h200, 8'h11);
        readCheck(12'h201, 8'h22);
        readCheck(12'h202, 8'h33);
        readCheck(12'h203, 8'h44);
        readCheck(12'h204, 8'h55);
        readCheck(12'h205, 8'h66);

        // Reset mid-load, coincident with a transfer, then reload from the base.
        applyStimulus_reset("rst3");
        waitFont("font3");
        txBytes = '{8'hA1, 8'hA2, 8'hA3};
        streamTx(1'b0);
        checkOutput("mid_count", load_count, 12'd3);
        load_valid = 1'b1;
        load_data  = 8'hEE;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitFont("font4");
        checkOutput("reload_count0", load_count, 12'd0);
        txBytes = '{8'h5A, 8'hC3};
        streamTx(1'b1);
        checkOutput("reload_count", load_count, 12'd2);
        readCheck(12'h200, 8'h5A);
        readCheck(12'h201, 8'hC3);
        readCheck(12'h202, 8'hA3);
        readCheck(12'h203, 8'h44);
        readCheck(12'h004, 8'hF0);

        // Overflow: fill 0x200-0xFFF without a last marker.
        applyStimulus_reset("rst4");
        waitFont("font5");
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 3583; i++) begin
            load_data = i[7:0];
            @(posedge clk);
            #1;
        end
        checkBit("pre_ovf_error", load_error, 1'b0);
        checkBit("pre_ovf_ready", load_ready, 1'b1);
        checkOutput("pre_ovf_count", load_count, 12'hDFF);
        load_data = 8'h77;
        @(posedge clk);
        #1;
        checkBit("ovf_error", load_error, 1'b1);
        checkBit("ovf_ready", load_ready, 1'b0);
        checkBit("ovf_hold", cpu_hold, 1'b1);
        checkBit("ovf_done", load_done, 1'b0);
        checkOutput("ovf_count", load_count, 12'hE00);
        repeat (5) @(posedge clk);
        #1;
        load_valid = 1'b0;
        checkOutput("ovf_hold_count", load_count, 12'hE00);
        checkBit("ovf_sticky_error", load_error, 1'b1);
        readCheck(12'hFFF, 8'h00);
        applyStimulus_reset("rst5");

        @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", 12'(expQ.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chip8_memory.md
Name: chip8_memory

Overview:
- 4 KiB byte-wide CHIP-8 memory. It is the responder on the CPU fetch interface (mem_read / mem_addr / mem_data).
- After reset it writes the standard 80-byte hex fontset into 0x000-0x04F. It then accepts a program image over a valid/ready byte stream into 0x200 upward.
- It holds the CPU in reset until the image is complete, then serves CPU reads.

Parameters:
- PROG_BASE, 12'h200, first address written by the loader.
- FONT_BASE, 12'h000, first address of the 80-byte fontset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  CPU read strobe.
- mem_addr  input  12  CPU byte address.
- mem_data  output  8  read data to the CPU; combinational from the array.
- load_valid  input  1  loader byte valid.
- load_data  input  8  loader byte.
- load_last  input  1  marks the final byte of the image; qualified by the transfer.
- load_ready  output  1  block accepts a loader byte this cycle.
- load_count  output  12  number of program bytes written so far.
- load_done  output  1  image complete; CPU may run.
- load_error  output  1  image overflowed past 0xFFF.
- cpu_hold  output  1  active-high reset request to the CPU.

Behaviour:
- States: FONT_INIT, LOAD, RUN, ERR.
- Reset (sync, any state, including mid-load):
  - state=FONT_INIT, font counter=0, write pointer=PROG_BASE, load_count=0.
  - load_ready=0, load_done=0, load_error=0, cpu_hold=1.
  - Array contents outside the font region are not cleared.
- FONT_INIT:
  - Each clock with reset low writes font[k] to FONT_BASE+k, k=0..79.
  - The fontset is standard CHIP-8: digit 0 = F0 90 90 90 F0 at 0x000-0x004; digit 1 = 20 60 20 20 70; digit F = F0 80 F0 80 80 at 0x04B-0x04F.
  - After the 80th write, state=LOAD. load_ready=1 on the 81st cycle after reset release.
- LOAD:
  - load_ready=1. A transfer occurs when load_valid and load_ready are both 1.
  - On a transfer: mem[ptr]=load_data, ptr+1, load_count+1.
  - Transfer with load_last=1: next state RUN; load_ready falls and load_done and cpu_hold update on the same edge.
  - Transfer writing 0xFFF with load_last=0: next state ERR. The byte at 0xFFF is written and ptr does not wrap.
  - load_valid=0 stalls indefinitely with no change.
- RUN:
  - load_ready=0, load_done=1, cpu_hold=0. Loader inputs are ignored.
  - The array is read-only; there is no CPU write port in this block.
- ERR:
  - load_ready=0, load_error=1, cpu_hold=1, load_done=0. Exit only by reset.
- Read path:
  - mem_data = mem[mem_addr] combinationally when mem_read=1 and state=RUN; otherwise 8'h00.
  - Zero latency is required: the CPU presents the address on one edge and samples data on the next edge.
  - Reads are valid at any address 0x000-0xFFF, including the font region.
- load_count:
  - Counts accepted program bytes and saturates at 3584 (0xE00).
  - It holds its value in RUN and ERR.
- Simultaneous reset and load transfer: reset wins, and the byte is not written.

Test Plan:
- Reset released, load_valid=0 → load_ready=0 for cycles 1-80 and 1 on cycle 81. In RUN after a later load: address 0x000 reads F0, 0x004 reads F0, 0x005 reads 20, 0x04F reads 80.
- Load bytes 60 0A 12 02 with last on the 4th byte → mem 0x200-0x203 hold 60 0A 12 02, load_count=4, load_done=1, cpu_hold=0 on the edge after the 4th transfer. mem_read=1 with mem_addr=0x201 gives mem_data=0A in the same cycle.
- Toggle load_valid on alternate cycles for 6 bytes → exactly 6 writes, load_count=6, and no byte is duplicated or dropped.
- Stream 3584 bytes with last=0 → load_error=1 and load_ready=0 after the byte at 0xFFF. cpu_hold stays 1 and further load_valid has no effect.
- Assert reset after 3 loaded bytes → all outputs return to reset values, font init repeats for 80 cycles, and a reload starts at 0x200 with load_count=0.
- In RUN with mem_read=0 at any address → mem_data=00. Before RUN with mem_read=1 → mem_data=00.
